// File: rtl/daq_sample_reader.sv
// daq_sample_reader: reads one conversion frame from a serial ADC.
// Each BUSY falling edge (if enabled) starts a frame. The block reads NUM_CHANNELS
// words MSB first and hands each one downstream over a valid/ready handshake.
// Ports: clk_i/reset_i (async, active-high); en_i enables readout; busy_i is the ADC BUSY
// (asynchronous to clk_i); sdata_i/cs_n_o/sclk_o form the ADC serial link;
// sample_o/chan_o/valid_o/ready_i carry the word handshake;
// frame_done_o pulses for one cycle at frame end; overrun_o is the sticky overrun flag.
module daq_sample_reader #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_BITS    = 16,
  parameter int SCLK_DIV     = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic        busy_i,
  input  logic        sdata_i,
  output logic        cs_n_o,
  output logic        sclk_o,
  output logic [15:0] sample_o,
  output logic [2:0]  chan_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_done_o,
  output logic        overrun_o
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST  = 5'(DATA_BITS - 1);
  localparam logic [2:0]       CHAN_LAST = 3'(NUM_CHANNELS - 1);
  localparam logic [15:0]      SAMPLE_MASK = 16'((17'h1 << DATA_BITS) - 17'h1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_OUTPUT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             busy_s1_q, busy_s1_d;
  logic             busy_s2_q, busy_s2_d;
  logic             busy_prev_q, busy_prev_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [2:0]       chan_cnt_q, chan_cnt_d;
  logic [15:0]      word_q, word_d;
  logic [15:0]      sample_q, sample_d;
  logic [2:0]       chan_q, chan_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             valid_q, valid_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic             busy_fall, busy_rise;

  always_comb begin
    busy_s1_d   = busy_i;
    busy_s2_d   = busy_s1_q;
    busy_prev_d = busy_s2_q;
    busy_fall   = busy_prev_q & ~busy_s2_q;
    busy_rise   = busy_s2_q & ~busy_prev_q;

    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    chan_cnt_d = chan_cnt_q;
    word_d     = word_q;
    sample_d   = sample_q;
    chan_d     = chan_q;
    overrun_d  = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (busy_fall) begin
          state_d    = ST_SETUP;
          div_d      = '0;
          bit_d      = '0;
          chan_cnt_d = '0;
        end
      end
      ST_SETUP: begin
        if (div_q == DIV_HALF) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // This edge is where sclk_o goes low->high; ADC data has been stable since the fall.
        if (div_q == DIV_HALF) begin
          word_d = {word_q[14:0], sdata_i};
        end
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d  = ST_OUTPUT;
            sample_d = word_q & SAMPLE_MASK;
            chan_d   = chan_cnt_q;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (ready_i) begin
          if (chan_cnt_q < CHAN_LAST) begin
            state_d    = ST_SHIFT;
            chan_cnt_d = chan_cnt_q + 1'b1;
            div_d      = '0;
            bit_d      = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new conversion starting mid-frame is flagged but does not disturb the frame.
    if (state_q != ST_IDLE && busy_rise) begin
      overrun_d = 1'b1;
    end

    if (!en_i) begin
      state_d    = ST_IDLE;
      div_d      = '0;
      bit_d      = '0;
      chan_cnt_d = '0;
      overrun_d  = 1'b0;
    end

    // Link outputs are registered from the next state so the ADC sees glitch-free edges.
    cs_n_d       = !(state_d inside {ST_SETUP, ST_SHIFT, ST_OUTPUT});
    sclk_d       = !(state_d == ST_SHIFT && div_d <= DIV_HALF);
    valid_d      = (state_d == ST_OUTPUT);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      busy_s1_q    <= 1'b1;
      busy_s2_q    <= 1'b1;
      busy_prev_q  <= 1'b1;
      div_q        <= '0;
      bit_q        <= '0;
      chan_cnt_q   <= '0;
      word_q       <= '0;
      sample_q     <= '0;
      chan_q       <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_s1_q    <= busy_s1_d;
      busy_s2_q    <= busy_s2_d;
      busy_prev_q  <= busy_prev_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      chan_cnt_q   <= chan_cnt_d;
      word_q       <= word_d;
      sample_q     <= sample_d;
      chan_q       <= chan_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign cs_n_o       = cs_n_q;
  assign sclk_o       = sclk_q;
  assign sample_o     = sample_q;
  assign chan_o       = chan_q;
  assign valid_o      = valid_q;
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: doc/daq_sample_reader.md
DAQ_SAMPLE_READER -- requirements
Module: daq_sample_reader

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8: channels read per conversion frame, range 1..8.
REQ-002 SHALL have parameter DATA_BITS, default 16: bits per channel word, range 1..16.
REQ-003 SHALL have parameter SCLK_DIV, default 2: clk_i cycles per sclk_o half-period, minimum 1.
REQ-004 clk_i  input  1  system clock; all logic on rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 en_i  input  1  readout enable; low aborts any frame and holds the block idle.
REQ-007 busy_i  input  1  ADC BUSY; asynchronous to clk_i; falling edge means conversion complete.
REQ-008 sdata_i  input  1  ADC serial data out, MSB first; ADC changes it after sclk_o falls.
REQ-009 cs_n_o  output  1  ADC chip select, active-low.
REQ-010 sclk_o  output  1  ADC serial clock; idles high.
REQ-011 sample_o  output  16  captured word, right-justified, upper bits zero when DATA_BITS<16.
REQ-012 chan_o  output  3  channel index of sample_o, 0..NUM_CHANNELS-1.
REQ-013 valid_o  output  1  sample_o/chan_o valid; held until ready_i.
REQ-014 ready_i  input  1  downstream accept; transfer occurs on a cycle with valid_o & ready_i.
REQ-015 frame_done_o  output  1  one-cycle pulse after the last channel's transfer.
REQ-016 overrun_o  output  1  sticky: new conversion started before the frame finished.

Function
REQ-017 busy_i SHALL pass through a 2-flop synchronizer; the falling edge is detected from the 2nd flop against a registered copy.
REQ-018 The FSM SHALL have states IDLE, SETUP, SHIFT, OUTPUT, DONE.
REQ-019 IDLE: cs_n_o=1, sclk_o=1, valid_o=0; a detected busy falling edge with en_i=1 -> SETUP, channel counter=0.
REQ-020 SETUP: cs_n_o=0, sclk_o=1 for SCLK_DIV cycles -> SHIFT with bit counter=0.
REQ-021 SHIFT: each bit is 2*SCLK_DIV cycles, sclk_o low for the first SCLK_DIV, high for the second.
REQ-022 sdata_i SHALL be shifted into the word register on the clk edge where sclk_o goes low->high.
REQ-023 After DATA_BITS bits (ending with sclk_o high) -> OUTPUT; sample_o/chan_o loaded, valid_o=1.
REQ-024 OUTPUT: cs_n_o stays 0, sclk_o stays high (serial clock stalled); sample_o/chan_o/valid_o stable until transfer.
REQ-025 On transfer: if channel counter < NUM_CHANNELS-1, increment it and return to SHIFT with valid_o=0 next cycle; else -> DONE.
REQ-026 DONE: one cycle, cs_n_o=1, frame_done_o=1, then IDLE.
REQ-027 Busy falling edges detected outside IDLE SHALL be ignored (no queuing).
REQ-028 A synchronized busy rising edge outside IDLE SHALL set overrun_o; the current frame continues unaffected.
REQ-029 en_i low (sampled synchronously) SHALL force IDLE next cycle from any state: cs_n_o=1, sclk_o=1, valid_o=0, counters=0, overrun_o cleared, no frame_done_o.
REQ-030 Bit counter SHALL be 5 bits and channel counter 3 bits; neither wraps within a frame.
REQ-031 Throughput with ready_i held high: one word per 2*SCLK_DIV*DATA_BITS+1 cycles after SETUP.

Reset
REQ-032 reset_i high SHALL asynchronously force: state IDLE, cs_n_o=1, sclk_o=1, valid_o=0, frame_done_o=0, overrun_o=0, sample_o=0, chan_o=0, counters=0, synchronizer flops=1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; after release, the next busy falling edge starts a fresh frame from channel 0.

Verification
REQ-034 Defaults, ready_i=1, ADC model shifts 0x1000+ch per channel: busy pulse -> 8 words 0x1000..0x1007, chan_o 0..7, one frame_done_o pulse, cs_n_o low throughout.
REQ-035 Latency: first rising edge sampling busy_i low = edge 0 -> cs_n_o low after edge 2, first valid_o high after edge 68.
REQ-036 Backpressure: ready_i low 20 cycles on channel 3 -> sclk_o held high, sample_o/valid_o stable, no data loss; remaining words correct.
REQ-037 Overrun: second busy pulse during channel 5 shift -> overrun_o=1 and stays 1, frame completes 8 words, no second frame starts.
REQ-038 en_i dropped during SHIFT of channel 2 -> next cycle cs_n_o=1, valid_o=0, no frame_done_o; re-enable plus busy pulse -> full frame from channel 0.
REQ-039 reset_i pulsed mid-SHIFT -> all outputs at reset values immediately (no clock edge needed); NUM_CHANNELS=1, DATA_BITS=12 rerun -> single word, sample_o[15:12]=0.
